// File: rtl/ss_capture.sv
// ss_capture: recovers four ASCII characters from a scanned seven-segment display.
// Define SS_CAPTURE_DP_EN to also capture the decimal points into DP.
module ss_capture #(
  parameter int STABLE_CYCLES = 16,
  parameter int STALE_CYCLES  = 1 << 20
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:4] SegmentDrivers,
  input  logic [7:0] SevenSegment,
  output logic [7:0] C1,
  output logic [7:0] C2,
  output logic [7:0] C3,
  output logic [7:0] C4,
  output logic [3:0] DP,
  output logic       Valid,
  output logic       Error,
  output logic       Stale
);
  localparam int SW = $clog2(STALE_CYCLES + 1);
`ifdef SS_CAPTURE_DP_EN
  localparam bit DP_EN = 1'b1;
`else
  localparam bit DP_EN = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;
  state_t      r_state;
  logic [3:0]  r_en_s1, r_en_s2, r_mask, r_dp;
  logic [7:0]  r_pat_s1, r_pat_s2;
  logic [11:0] r_ref;
  logic [15:0] r_cnt;
  logic [SW-1:0] r_stale;
  logic [7:0]  r_chr [4];
  logic [11:0] w_samp;
  logic        w_one, w_multi, w_cap, w_bad;
  logic [1:0]  w_idx;
  logic [7:0]  w_chr;
  // Synchronisers hold the active-high view so a cleared stage means "nothing driven".
  assign w_samp  = {r_en_s2, r_pat_s2[7] & DP_EN, r_pat_s2[6:0]};
  assign w_one   = r_en_s2 != 4'h0 && (r_en_s2 & (r_en_s2 - 4'd1)) == 4'h0;
  assign w_multi = r_en_s2 != 4'h0 && !w_one;
  assign w_cap   = r_state == SETTLE && r_cnt == 16'(STABLE_CYCLES);
  assign w_idx   = r_ref[11] ? 2'd0 : r_ref[10] ? 2'd1 : r_ref[9] ? 2'd2 : 2'd3;
  assign {C1, C2, C3, C4} = {r_chr[0], r_chr[1], r_chr[2], r_chr[3]};
  assign DP    = r_dp;
  assign Stale = r_stale == SW'(STALE_CYCLES);
  always_comb begin
    w_bad = 1'b0;
    case (r_ref[6:0])
      7'h3F: w_chr = 8'h30;
      7'h06: w_chr = 8'h31;
      7'h5B: w_chr = 8'h32;
      7'h4F: w_chr = 8'h33;
      7'h66: w_chr = 8'h34;
      7'h6D: w_chr = 8'h35;
      7'h7D: w_chr = 8'h36;
      7'h07: w_chr = 8'h37;
      7'h7F: w_chr = 8'h38;
      7'h6F: w_chr = 8'h39;
      7'h77: w_chr = 8'h41;
      7'h7C: w_chr = 8'h62;
      7'h39: w_chr = 8'h43;
      7'h5E: w_chr = 8'h64;
      7'h79: w_chr = 8'h45;
      7'h71: w_chr = 8'h46;
      7'h00: w_chr = 8'h20;
      default: begin
        w_chr = 8'h3F;
        w_bad = 1'b1;
      end
    endcase
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state  <= IDLE;
      r_en_s1  <= '0;
      r_en_s2  <= '0;
      r_pat_s1 <= '0;
      r_pat_s2 <= '0;
      r_ref    <= '0;
      r_cnt    <= '0;
      r_stale  <= '0;
      r_mask   <= '0;
      r_dp     <= '0;
      r_chr    <= '{default: 8'h20};
      Valid    <= 1'b0;
      Error    <= 1'b0;
    end else begin
      r_en_s1  <= ~SegmentDrivers;
      r_en_s2  <= r_en_s1;
      r_pat_s1 <= ~SevenSegment;
      r_pat_s2 <= r_pat_s1;
      Valid    <= r_mask == 4'hF;
      r_mask   <= (r_mask == 4'hF ? 4'h0 : r_mask) | (w_cap ? r_ref[11:8] : 4'h0);
      r_stale  <= w_cap ? '0 : Stale ? r_stale : r_stale + SW'(1);
      Error    <= Error | w_multi | (w_cap & w_bad);
      if (w_cap) begin
        r_chr[w_idx] <= w_chr;
        r_dp <= r_ref[7] ? r_dp | r_ref[11:8] : r_dp & ~r_ref[11:8];
      end
      // The capture edge also evaluates the current sample so no sample is lost.
      if (w_multi) r_state <= IDLE;
      else if (r_state == SETTLE && w_samp == r_ref) begin
        r_state <= w_cap ? HELD : SETTLE;
        r_cnt   <= r_cnt + 16'd1;
      end else if (r_state == HELD && w_samp == r_ref) r_state <= HELD;
      else if (w_one) begin
        r_state <= SETTLE;
        r_cnt   <= 16'd1;
        r_ref   <= w_samp;
      end else r_state <= IDLE;
    end
  end
endmodule

// File: tb/tb_ss_capture.sv
// tb_ss_capture: random and directed scans checked against a run-length reference model.
module tb_ss_capture;
  localparam int STABLE = 16;
  localparam int STALE  = 300;
`ifdef SS_CAPTURE_DP_EN
  localparam bit DPEN = 1'b1;
`else
  localparam bit DPEN = 1'b0;
`endif
  logic       Clk = 1'b0, Reset = 1'b1;
  logic [7:4] SegmentDrivers = 4'hF;
  logic [7:0] SevenSegment = 8'hFF;
  logic [7:0] C1, C2, C3, C4;
  logic [3:0] DP;
  logic       Valid, Error, Stale;
  int total = 0, bad = 0, nvalid = 0;
  logic [6:0] seg_tab [17] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F,
                               7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71, 7'h00};
  string chr_tab = "0123456789AbCdEF ";
  logic [11:0] m_s1, m_s2, m_prev;
  int          m_run, m_stale;
  logic [7:0]  m_chr [4];
  logic [3:0]  m_dp, m_mask;
  logic        m_valid, m_err;

  ss_capture #(.STABLE_CYCLES(STABLE), .STALE_CYCLES(STALE)) dut (
    .Clk(Clk), .Reset(Reset), .SegmentDrivers(SegmentDrivers), .SevenSegment(SevenSegment),
    .C1(C1), .C2(C2), .C3(C3), .C4(C4), .DP(DP), .Valid(Valid), .Error(Error), .Stale(Stale)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] decode(input logic [6:0] p);
    for (int i = 0; i < 17; i++) if (seg_tab[i] == p) return {1'b0, chr_tab[i]};
    return {1'b1, 8'h3F};
  endfunction

  // A digit is captured once its sample has been seen STABLE times in a row.
  task automatic model_edge(input logic rst, input logic [3:0] en, input logic [7:0] pat);
    logic [11:0] cur;
    logic [8:0]  d;
    int idx;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_prev = '0; m_run = 0; m_stale = 0;
      m_chr = '{default: 8'h20}; m_dp = '0; m_mask = '0; m_valid = 0; m_err = 0;
      return;
    end
    cur = m_s2;
    m_valid = m_mask == 4'hF;
    if (m_valid) m_mask = 4'h0;
    if (m_run == STABLE && $countones(m_prev[11:8]) == 1) begin
      idx = 0;
      for (int i = 0; i < 4; i++) if (m_prev[11-i]) idx = i;
      d = decode(m_prev[6:0]);
      m_chr[idx] = d[7:0];
      m_err = m_err | d[8];
      m_dp[3-idx] = m_prev[7];
      m_mask = m_mask | m_prev[11:8];
      m_stale = 0;
    end else if (m_stale < STALE) m_stale++;
    if ($countones(cur[11:8]) > 1) m_err = 1'b1;
    m_run = (cur == m_prev) ? (m_run > STABLE ? m_run : m_run + 1) : 1;
    m_prev = cur;
    m_s2 = m_s1;
    m_s1 = {en, pat[7] & DPEN, pat[6:0]};
  endtask

  task automatic step(input logic [3:0] en, input logic [7:0] pat, input logic rst);
    Reset = rst;
    SegmentDrivers = ~en;
    SevenSegment = ~pat;
    @(posedge Clk);
    model_edge(rst, en, pat);
    #1;
    check("C1", C1, m_chr[0]);
    check("C2", C2, m_chr[1]);
    check("C3", C3, m_chr[2]);
    check("C4", C4, m_chr[3]);
    check("DP", DP, m_dp);
    check("Valid", Valid, m_valid);
    check("Error", Error, m_err);
    check("Stale", Stale, m_stale == STALE);
    if (Valid) nvalid++;
  endtask

  task automatic hold(input logic [3:0] en, input logic [7:0] pat, input int n);
    repeat (n) step(en, pat, 1'b0);
  endtask

  task automatic do_reset(input int n);
    repeat (n) step(4'h0, 8'h00, 1'b1);
  endtask

  task automatic scan(input logic [31:0] pats);
    for (int i = 0; i < 4; i++) hold(4'h8 >> i, pats[31-8*i -: 8], 20);
  endtask

  initial begin
    logic [3:0] en;
    logic [7:0] pat;
    do_reset(3);
    check("rst_C1", C1, 8'h20);
    check("rst_C4", C4, 8'h20);
    check("rst_DP", DP, 4'h0);
    check("rst_Valid", Valid, 1'b0);
    check("rst_Error", Error, 1'b0);
    check("rst_Stale", Stale, 1'b0);
    nvalid = 0;
    scan(32'h065B4F66);
    scan(32'h065B4F66);
    hold(4'h0, 8'h00, 4);
    check("scan_nvalid", nvalid, 2);
    check("scan_C1", C1, 8'h31);
    check("scan_C2", C2, 8'h32);
    check("scan_C3", C3, 8'h33);
    check("scan_C4", C4, 8'h34);
    do_reset(2);
    hold(4'h2, 8'h6D, 10);
    step(4'h2, 8'h69, 1'b0);
    hold(4'h0, 8'h00, 25);
    check("glitch_C3", C3, 8'h20);
    check("glitch_Error", Error, 1'b0);
    hold(4'h1, 8'h55, 20);
    hold(4'h0, 8'h00, 3);
    check("bad_C4", C4, 8'h3F);
    check("bad_Error", Error, 1'b1);
    do_reset(2);
    nvalid = 0;
    hold(4'h3, 8'h06, 5);
    hold(4'h0, 8'h00, 10);
    check("multi_Error", Error, 1'b1);
    scan(32'h065B4F66);
    hold(4'h0, 8'h00, 4);
    check("multi_sticky", Error, 1'b1);
    do_reset(2);
    nvalid = 0;
    hold(4'h8, 8'h06, 20);
    hold(4'h4, 8'h5B, 20);
    hold(4'h2, 8'h4F, 8);
    do_reset(2);
    check("midrst_C1", C1, 8'h20);
    check("midrst_C2", C2, 8'h20);
    check("midrst_nvalid", nvalid, 0);
    scan(32'h065B4F66);
    hold(4'h0, 8'h00, 4);
    check("midrst_scan_nvalid", nvalid, 1);
    check("midrst_C3", C3, 8'h33);
    do_reset(2);
    hold(4'h8, 8'h07, 3 * STABLE);
    check("long_C1", C1, 8'h37);
    hold(4'h0, 8'h00, STALE);
    check("stale_set", Stale, 1'b1);
    for (int s = 0; s < 120; s++) begin
      int r;
      r = $urandom_range(0, 29);
      en = r == 1 ? (4'h3 | (4'($urandom_range(0, 15)) & 4'hC)) :
           r < 4 ? 4'h0 : 4'h1 << $urandom_range(0, 3);
      pat = $urandom_range(0, 4) == 0 ? 8'($urandom) :
            {1'($urandom), seg_tab[$urandom_range(0, 16)]};
      if (r == 0) do_reset(2);
      else hold(en, pat, $urandom_range(1, 40));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
